// File: rtl/sub_sched.sv
// sub_sched: two requesters share one SLICE-bit serial subtractor through a round-robin front end.
// Defining SUB_SCHED_ZERO_FLAG_EN adds the resp_zero output.
module sub_sched #(
  parameter int N     = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_bin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_bin,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_diff,
  output logic         resp_bo,
  output logic         resp_id,
`ifdef SUB_SCHED_ZERO_FLAG_EN
  output logic         resp_zero,
`endif
  output logic         busy
);

  localparam int NS = N / SLICE;
  localparam int KW = $clog2(NS + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_END = KW'(NS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [N-1:0]    diff_r;
  logic            borrow_r;
  logic            last_r;
  logic            id_r;
  logic [KW-1:0]   k_r;
  logic            grant0_s;
  logic            grant1_s;
  logic [SLICE-1:0] slice_s;
  logic            slice_bo_s;
  logic [IW-1:0]   base_s;

  // Top bit of the widened difference is the borrow out of the slice.
  function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic bin);
    logic [SLICE:0] t;
    t = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bin};
    return t;
  endfunction

  // Round-robin grant; offered only while idle, last_r=1 means requester 0 goes next.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_r;
        grant1_s = ~last_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Operands shift right each cycle so the live slice always sits in the low bits.
  always_comb begin
    {slice_bo_s, slice_s} = sub_slice(a_r[SLICE-1:0], b_r[SLICE-1:0], borrow_r);
    base_s = IW'(int'(k_r) * SLICE);
  end

  // Control FSM, serial datapath and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= {N{1'b0}};
      b_r        <= {N{1'b0}};
      diff_r     <= {N{1'b0}};
      borrow_r   <= 1'b0;
      last_r     <= 1'b1;
      id_r       <= 1'b0;
      k_r        <= {KW{1'b0}};
      resp_valid <= 1'b0;
      resp_diff  <= {N{1'b0}};
      resp_bo    <= 1'b0;
      resp_id    <= 1'b0;
      busy       <= 1'b0;
`ifdef SUB_SCHED_ZERO_FLAG_EN
      resp_zero  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant1_s) begin
            a_r      <= req1_a;
            b_r      <= req1_b;
            borrow_r <= req1_bin;
            id_r     <= 1'b1;
            last_r   <= 1'b1;
            k_r      <= {KW{1'b0}};
            busy     <= 1'b1;
            state_r  <= CALC;
          end else if (grant0_s) begin
            a_r      <= req0_a;
            b_r      <= req0_b;
            borrow_r <= req0_bin;
            id_r     <= 1'b0;
            last_r   <= 1'b0;
            k_r      <= {KW{1'b0}};
            busy     <= 1'b1;
            state_r  <= CALC;
          end
        end
        CALC: begin
          // One extra edge after the last slice publishes the finished result.
          if (k_r == K_END) begin
            resp_valid <= 1'b1;
            resp_diff  <= diff_r;
            resp_bo    <= borrow_r;
            resp_id    <= id_r;
`ifdef SUB_SCHED_ZERO_FLAG_EN
            resp_zero  <= (diff_r == {N{1'b0}});
`endif
            state_r    <= DONE;
          end else begin
            diff_r[base_s +: SLICE] <= slice_s;
            borrow_r <= slice_bo_s;
            a_r      <= a_r >> SLICE;
            b_r      <= b_r >> SLICE;
            k_r      <= k_r + KW'(1'b1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef SUB_SCHED_ZERO_FLAG_EN
            resp_zero  <= 1'b0;
`endif
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_sched.sv
// Bench for sub_sched: table vectors, randomized arbitration/arithmetic against a reference model,
// plus hand sequences for back-pressure, alternation and reset abort.
module tb_sub_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_bin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_bin;
  logic [15:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_bo, resp_id, busy;
  logic [15:0] resp_diff;
`ifdef SUB_SCHED_ZERO_FLAG_EN
  logic        resp_zero;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic last_g;  // model: 1 -> requester 0 wins a tie next

  always #5 clk = ~clk;

  sub_sched #(.N(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_bin(req0_bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_bin(req1_bin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_diff(resp_diff), .resp_bo(resp_bo),
    .resp_id(resp_id),
`ifdef SUB_SCHED_ZERO_FLAG_EN
    .resp_zero(resp_zero),
`endif
    .busy(busy)
  );

  typedef struct {
    string       name;
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] ediff;
    logic        ebo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  // Reference arithmetic from the definition: unsigned a - b - bin.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int d;
    logic [31:0] du;
    d = int'(a) - int'(b) - int'(bin);
    du = d;
    return {(d < 0), du[15:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
  endtask

  task automatic do_txn(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic bi0,
                        input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic bi1,
                        input logic ewin, input logic [15:0] ediff, input logic ebo, input string tag);
    int lat;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_bin = bi0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_bin = bi1;
    #1;
    chk({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, ewin, ~ewin});
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 32'd5);
    chk({tag, ".diff"}, {16'd0, resp_diff}, {16'd0, ediff});
    chk({tag, ".bo_id"}, {30'd0, resp_bo, resp_id}, {30'd0, ebo, ewin});
`ifdef SUB_SCHED_ZERO_FLAG_EN
    chk({tag, ".zero"}, {31'd0, resp_zero}, {31'd0, (ediff == 16'd0)});
`endif
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".idle"}, {30'd0, busy, resp_valid}, 32'd0);
    last_g = ewin;
  endtask

  vec_t vecs[8];

  initial begin
    logic        v0, v1, win;
    logic [15:0] a0, b0, a1, b1;
    logic        bi0, bi1;
    logic [16:0] r;
    logic [1:0]  g[4];
    int          ng, both, cyc, bad;

    vecs[0] = '{"r0_basic",   1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{"r1_under",   1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{"r1_eq_bin",  1'b1, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{"r0_zero",    1'b0, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
    vecs[4] = '{"r0_allones", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{"r1_wrap",    1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{"r0_ripple",  1'b0, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[7] = '{"r1_mid",     1'b1, 16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 16'd0; req0_b = 16'd0; req0_bin = 1'b0;
    req1_valid = 1'b0; req1_a = 16'd0; req1_b = 16'd0; req1_bin = 1'b0;
    resp_ready = 1'b0;
    last_g = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset_outputs", {resp_diff, resp_valid, resp_bo, resp_id, busy, req0_ready, req1_ready},
        {16'd0, 6'd0});

    // Table vectors: one requester valid at a time.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].sel)
        do_txn(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].bin,
               1'b1, vecs[i].ediff, vecs[i].ebo, vecs[i].name);
      else
        do_txn(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, 16'd0, 16'd0, 1'b0,
               1'b0, vecs[i].ediff, vecs[i].ebo, vecs[i].name);
    end

    // Random requests with round-robin model.
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = 16'($urandom); b0 = 16'($urandom); bi0 = 1'($urandom_range(0, 1));
      a1 = 16'($urandom); b1 = 16'($urandom); bi1 = 1'($urandom_range(0, 1));
      win = (v0 && v1) ? ~last_g : v1;
      r = win ? ref_sub(a1, b1, bi1) : ref_sub(a0, b0, bi0);
      do_txn(v0, a0, b0, bi0, v1, a1, b1, bi1, win, r[15:0], r[16], "rand");
    end

    // Both requesters valid continuously after reset: grants alternate from 0.
    do_reset();
    @(negedge clk);
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0001; req0_bin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0020; req1_b = 16'h0002; req1_bin = 1'b0;
    #1;
    ng = 0; both = 0; cyc = 0;
    while (ng < 4 && cyc < 80) begin
      if (req0_ready && req1_ready) both++;
      if (req0_ready) begin g[ng] = 2'd0; ng++; end
      else if (req1_ready) begin g[ng] = 2'd1; ng++; end
      if (ng < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alt.count", ng, 32'd4);
    chk("alt.both_ready", both, 32'd0);
    for (int i = 0; i < 4; i++) chk("alt.order", {30'd0, g[i]}, i % 2);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("alt.drain", {31'd0, busy}, 32'd0);
    resp_ready = 1'b0;
    last_g = 1'b1;

    // Back-pressure: hold DONE for 10 cycles with a competing request pending.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0234; req0_bin = 1'b0;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold", {10'd0, resp_diff, resp_bo, resp_id, busy, req0_ready, req1_ready, resp_valid},
          {10'd0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release", {29'd0, busy, resp_valid, req0_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    req0_valid = 1'b0;
    last_g = 1'b0;

    // Reset during the third CALC cycle of a requester-0 operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = 1'b1;
    chk("abort_outputs", {resp_diff, resp_valid, resp_bo, resp_id, busy, req0_ready, req1_ready},
        {16'd0, 6'd0});
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid || busy) bad++;
    end
    chk("abort_no_resp", bad, 32'd0);
    r = ref_sub(16'h4321, 16'h1111, 1'b1);
    do_txn(1'b1, 16'h4321, 16'h1111, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0,
           1'b0, r[15:0], r[16], "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sub_sched.md
SUB_SCHED -- requirements
Module: sub_sched

Interface
REQ-001 Parameter N, default 16, operand/result width in bits.
REQ-002 Parameter SLICE, default 4, bits subtracted per cycle; N SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 req0_a, req0_b  input  N each  requester 0 minuend, subtrahend.
REQ-008 req0_bin  input  1  requester 0 borrow-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_bin  as REQ-005..008 for requester 1.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer takes result.
REQ-012 resp_diff  output  N  difference.
REQ-013 resp_bo  output  1  borrow-out.
REQ-014 resp_id  output  1  index of requester that owns the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, CALC, DONE; one operation in flight at a time; the single slice subtractor is shared by both requesters.
REQ-017 IDLE: reqX_ready high only for the arbitration winner, combinational, only in IDLE; both ready SHALL never be high together.
REQ-018 Arbitration round-robin: sole valid requester wins; with both valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 On handshake edge (valid & ready): latch a, b, bin, id; slice index := 0; borrow := bin; go CALC; update last-grant.
REQ-020 CALC: each edge computes slice k bits [k*SLICE +: SLICE] = a_k - b_k - borrow (mod 2^SLICE), stores it, updates borrow, increments k; after slice N/SLICE-1 go DONE.
REQ-021 Latency: resp_valid SHALL rise exactly N/SLICE+1 edges after the handshake edge (5 for defaults).
REQ-022 Arithmetic: resp_diff = (a - b - bin) mod 2^N; resp_bo = 1 iff a < b + bin, unsigned.
REQ-023 DONE: resp_valid high; resp_diff, resp_bo, resp_id held stable until resp_valid & resp_ready edge, then IDLE.
REQ-024 No new request accepted in CALC or DONE, including the cycle resp_ready is taken; first new grant occurs in the following IDLE cycle.
REQ-025 Requests whose valid drops before being granted are not remembered.

Reset
REQ-026 rst high at an edge: state := IDLE, resp_valid := 0, resp_diff := 0, resp_bo := 0, resp_id := 0, busy := 0, last-grant := 1 (requester 0 next), borrow := 0, k := 0.
REQ-027 rst mid-CALC or mid-DONE aborts the operation; no response produced for it; rst dominates all simultaneous handshakes.

Configuration
REQ-028 Macro SUB_SCHED_ZERO_FLAG_EN defined: extra output resp_zero (1 bit) high while resp_valid and resp_diff == 0, reset 0; undefined: port and logic absent, all other behaviour identical.

Verification
REQ-029 Req0 only, a=0x1234, b=0x0234, bin=0 -> 5 edges later resp_valid, diff=0x1000, bo=0, id=0.
REQ-030 Req1 only, a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bo=1, id=1; a=0x0005,b=0x0005,bin=1 -> diff=0xFFFF, bo=1.
REQ-031 Both valid continuously after reset, resp_ready=1 -> grants alternate 0,1,0,1; never both ready high.
REQ-032 resp_ready held 0 for 10 cycles in DONE -> outputs stable, req ready low, busy high; release -> IDLE next edge.
REQ-033 rst asserted on 3rd CALC cycle -> next cycle all outputs at reset values, no response; next grant to requester 0.
REQ-034 With SUB_SCHED_ZERO_FLAG_EN, a=0x8000,b=0x7FFF,bin=1 -> diff=0x0000, bo=0, resp_zero=1.
